// File: rtl/ecall_pkg.sv
// ---------------------------------------------------------------------------
// ecall_pkg
// Shared definitions for the ecall controller: the service codes decoded from
// a7, the register-file address of a0, and the controller state type.
// Optional build macro used elsewhere in this slice: ECALL_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package ecall_pkg;

   // Service codes carried in a7 when an ecall is executed
   localparam logic [31:0] PRINT_INT = 32'd1;
   localparam logic [31:0] READ_INT  = 32'd5;
   localparam logic [31:0] EXIT      = 32'd10;
   localparam logic [31:0] READ_TEST = 32'd11;

   // Register-file index of a0 (x10), the destination of every read service
   localparam logic [4:0]  A0_ADDR   = 5'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHOW,
      S_WAIT_IN,
      S_WRITE_A0,
      S_DONE,
      S_HALT
   } ecall_state_t;

   // True for the service codes the controller knows how to handle
   function automatic logic isKnownService(input logic [31:0] code);
      return (code == PRINT_INT) || (code == READ_INT) ||
             (code == EXIT)      || (code == READ_TEST);
   endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// ---------------------------------------------------------------------------
// btn_edge_sync
// Brings the raw, asynchronous confirm button into the clk domain with a
// two-flop synchronizer and produces a registered one-cycle pulse on each
// rising edge of the synchronized level.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous, active-low reset
//   i_btn   - raw button level
//   o_edge  - single-cycle pulse, three clocks after the button rises
// ---------------------------------------------------------------------------
module btn_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_edge
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // Two synchronizer stages, then a delayed copy of the synchronized level so
   // the rising edge can be detected; the pulse itself is registered so the
   // FSM sees a clean, glitch-free single-cycle strobe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         o_edge  <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         o_edge  <= r_sync2 & ~r_prev;
      end
   end

endmodule

// File: rtl/ecall_controller.sv
// ---------------------------------------------------------------------------
// ecall_controller
// Services RISC-V ecall instructions for a small FPGA CPU: print to the
// display, read the switches or the test-case number into a0, and halt.
// The CPU is stalled while a service is in progress.
// Optional build macro: ECALL_TIMEOUT_EN - adds a confirm-wait timeout of
// TIMEOUT_CYCLES clocks in SHOW and WAIT_IN.
// Ports:
//   clk, reset              - clock and asynchronous active-low reset
//   ecall_valid             - ecall present (held while the CPU is stalled)
//   a7_val, a0_val          - service code and argument registers
//   io_input, test_case     - switch value and selected test-case number
//   confirm_btn             - raw confirm push-button
//   cpu_stall               - freeze PC and writeback
//   rf_we/rf_waddr/rf_wdata - register-file write request (beats CPU WB)
//   disp_data/disp_valid    - print latch to the display
//   led_out, halted, err    - status LEDs, halt flag, one-cycle error pulse
// ---------------------------------------------------------------------------
module ecall_controller
   import ecall_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ecall_valid,
   input  logic [31:0] a7_val,
   input  logic [31:0] a0_val,
   input  logic [31:0] io_input,
   input  logic [31:0] test_case,
   input  logic        confirm_btn,
   output logic        cpu_stall,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] disp_data,
   output logic        disp_valid,
   output logic [7:0]  led_out,
   output logic        halted,
   output logic        err
);

   ecall_state_t r_state;
   logic         w_confirmEdge;

`ifdef ECALL_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] r_toCount;
`endif

   btn_edge_sync u_btnSync (
      .clk    (clk),
      .reset  (reset),
      .i_btn  (confirm_btn),
      .o_edge (w_confirmEdge)
   );

   // The stall must act in the same cycle the ecall is decoded, so it is
   // combinational. DONE deliberately drops it so the CPU retires the ecall.
   assign cpu_stall = (r_state == S_SHOW)     || (r_state == S_WAIT_IN) ||
                      (r_state == S_WRITE_A0) || (r_state == S_HALT)    ||
                      ((r_state == S_IDLE) && ecall_valid && isKnownService(a7_val));

   // Main controller. rf_we is raised on the transition into WRITE_A0 so it is
   // high for exactly the one cycle spent there; rf_waddr and rf_wdata are only
   // ever loaded, never cleared, so they hold their last values between
   // writes. The timeout counter idles at zero outside SHOW/WAIT_IN and is
   // only incremented while staying in one of them, which clears it on entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         led_out    <= 8'h00;
         disp_data  <= 32'h0;
         disp_valid <= 1'b0;
         rf_wdata   <= 32'h0;
         rf_waddr   <= 5'd0;
         rf_we      <= 1'b0;
         err        <= 1'b0;
         halted     <= 1'b0;
`ifdef ECALL_TIMEOUT_EN
         r_toCount  <= 32'h0;
`endif
      end else begin
         rf_we <= 1'b0;
         err   <= 1'b0;
`ifdef ECALL_TIMEOUT_EN
         r_toCount <= 32'h0;
`endif
         case (r_state)
            S_IDLE: begin
               if (ecall_valid) begin
                  case (a7_val)
                     PRINT_INT: begin
                        disp_data  <= a0_val;
                        disp_valid <= 1'b1;
                        r_state    <= S_SHOW;
                     end
                     READ_INT: begin
                        led_out[7] <= 1'b1;
                        r_state    <= S_WAIT_IN;
                     end
                     EXIT: begin
                        led_out[0] <= 1'b1;
                        halted     <= 1'b1;
                        r_state    <= S_HALT;
                     end
                     READ_TEST: begin
                        rf_wdata   <= test_case;
                        led_out[1] <= 1'b1;
                        rf_we      <= 1'b1;
                        rf_waddr   <= A0_ADDR;
                        r_state    <= S_WRITE_A0;
                     end
                     default: err <= 1'b1;
                  endcase
               end
            end
            S_SHOW: begin
               if (w_confirmEdge) begin
                  r_state <= S_DONE;
`ifdef ECALL_TIMEOUT_EN
               end else if (r_toCount == TO_LAST) begin
                  err     <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_toCount <= r_toCount + 32'd1;
`endif
               end
            end
            S_WAIT_IN: begin
               if (w_confirmEdge) begin
                  rf_wdata   <= io_input;
                  led_out[7] <= 1'b0;
                  rf_we      <= 1'b1;
                  rf_waddr   <= A0_ADDR;
                  r_state    <= S_WRITE_A0;
`ifdef ECALL_TIMEOUT_EN
               end else if (r_toCount == TO_LAST) begin
                  err        <= 1'b1;
                  rf_wdata   <= 32'h0;
                  led_out[7] <= 1'b0;
                  rf_we      <= 1'b1;
                  rf_waddr   <= A0_ADDR;
                  r_state    <= S_WRITE_A0;
               end else begin
                  r_toCount <= r_toCount + 32'd1;
`endif
               end
            end
            S_WRITE_A0: begin
               led_out[1] <= 1'b0;
               r_state    <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ecall_controller.sv
// ---------------------------------------------------------------------------
// tb_ecall_controller
// Self-checking bench for ecall_controller. A small service-level model keeps
// the values the display latch and register-file port must be holding; each
// ecall transaction is checked cycle by cycle against the timing rules of the
// controller. Build with ECALL_TIMEOUT_EN to add the timeout scenario.
// ---------------------------------------------------------------------------
module tb_ecall_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ecall_valid = 1'b0;
   logic [31:0] a7_val = 32'h0;
   logic [31:0] a0_val = 32'h0;
   logic [31:0] io_input = 32'h0;
   logic [31:0] test_case = 32'h0;
   logic        confirm_btn = 1'b0;
   logic        cpu_stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] disp_data;
   logic        disp_valid;
   logic [7:0]  led_out;
   logic        halted;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Model of the values that must be held on the output latches
   logic [31:0] mDisp;
   logic        mDispValid;
   logic [31:0] mWdata;
   logic [4:0]  mWaddr;

   ecall_controller #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .ecall_valid (ecall_valid),
      .a7_val      (a7_val),
      .a0_val      (a0_val),
      .io_input    (io_input),
      .test_case   (test_case),
      .confirm_btn (confirm_btn),
      .cpu_stall   (cpu_stall),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .disp_data   (disp_data),
      .disp_valid  (disp_valid),
      .led_out     (led_out),
      .halted      (halted),
      .err         (err)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Service classification straight from the service-code table:
   // 0 unknown, 1 print, 2 read switches, 3 read test case, 4 exit
   function automatic int serviceKind(input logic [31:0] code);
      if (code == 32'd1)  return 1;
      if (code == 32'd5)  return 2;
      if (code == 32'd11) return 3;
      if (code == 32'd10) return 4;
      return 0;
   endfunction

   // One comparison, counted and reported on failure
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one clock and land on the following falling edge for sampling
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Latched outputs must match the model whenever no write/print is active
   task automatic checkRetained(input string tag);
      checkOutput({tag, "_disp_data"},  disp_data,  mDisp);
      checkOutput({tag, "_disp_valid"}, disp_valid, mDispValid);
      checkOutput({tag, "_rf_wdata"},   rf_wdata,   mWdata);
      checkOutput({tag, "_rf_waddr"},   rf_waddr,   mWaddr);
   endtask

   task automatic applyStimulus(input logic [31:0] code, input logic [31:0] a0,
                                input logic [31:0] io, input logic [31:0] tc);
      a7_val      = code;
      a0_val      = a0;
      io_input    = io;
      test_case   = tc;
      ecall_valid = 1'b1;
   endtask

   // Press at the current falling edge; the press takes effect on the 4th
   // rising edge. The first three must leave the stall up with no write.
   task automatic waitConfirm(input string tag);
      confirm_btn = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 2) confirm_btn = 1'b0;
         if (i < 4) begin
            checkOutput({tag, "_stall_wait"}, cpu_stall, 1'b1);
            checkOutput({tag, "_we_wait"},    rf_we,     1'b0);
         end
      end
   endtask

   // One complete ecall transaction checked against the service rules
   task automatic runEcall(input string tag, input logic [31:0] code,
                           input logic [31:0] a0, input logic [31:0] io,
                           input logic [31:0] tc, input int waitCycles,
                           input bit strayPress);
      int kind;
      kind = serviceKind(code);
      if (strayPress) begin
         confirm_btn = 1'b1;
         tick();
         tick();
         confirm_btn = 1'b0;
         repeat (4) tick();
         checkOutput({tag, "_idle_stall"}, cpu_stall, 1'b0);
      end
      applyStimulus(code, a0, ~io, tc);
      #1;
      checkOutput({tag, "_stall_decode"}, cpu_stall, (kind != 0) ? 1'b1 : 1'b0);
      tick();
      case (kind)
         1: begin
            mDisp      = a0;
            mDispValid = 1'b1;
            checkRetained({tag, "_show"});
            checkOutput({tag, "_stall_show"}, cpu_stall, 1'b1);
            repeat (waitCycles) begin
               tick();
               checkOutput({tag, "_stall_hold"}, cpu_stall, 1'b1);
            end
            waitConfirm(tag);
            checkOutput({tag, "_stall_done"}, cpu_stall, 1'b0);
            checkOutput({tag, "_we_done"},    rf_we,     1'b0);
         end
         2: begin
            checkOutput({tag, "_led_wait"},   led_out,   8'h80);
            checkOutput({tag, "_stall_wait"}, cpu_stall, 1'b1);
            repeat (waitCycles) begin
               tick();
               checkOutput({tag, "_stall_hold"}, cpu_stall, 1'b1);
               checkOutput({tag, "_we_hold"},    rf_we,     1'b0);
            end
            io_input = io;
            waitConfirm(tag);
            mWdata = io;
            mWaddr = 5'd10;
            checkOutput({tag, "_we"},       rf_we,     1'b1);
            checkOutput({tag, "_waddr"},    rf_waddr,  5'd10);
            checkOutput({tag, "_wdata"},    rf_wdata,  io);
            checkOutput({tag, "_led_wr"},   led_out,   8'h00);
            checkOutput({tag, "_stall_wr"}, cpu_stall, 1'b1);
            tick();
            checkOutput({tag, "_stall_done"}, cpu_stall, 1'b0);
            checkOutput({tag, "_we_done"},    rf_we,     1'b0);
         end
         3: begin
            mWdata = tc;
            mWaddr = 5'd10;
            checkOutput({tag, "_we"},       rf_we,     1'b1);
            checkOutput({tag, "_waddr"},    rf_waddr,  5'd10);
            checkOutput({tag, "_wdata"},    rf_wdata,  tc);
            checkOutput({tag, "_led_wr"},   led_out,   8'h02);
            checkOutput({tag, "_stall_wr"}, cpu_stall, 1'b1);
            tick();
            checkOutput({tag, "_stall_done"}, cpu_stall, 1'b0);
            checkOutput({tag, "_we_done"},    rf_we,     1'b0);
            checkOutput({tag, "_led_done"},   led_out,   8'h00);
         end
         default: begin
            checkOutput({tag, "_err"},   err,       1'b1);
            checkOutput({tag, "_stall"}, cpu_stall, 1'b0);
            checkOutput({tag, "_we"},    rf_we,     1'b0);
         end
      endcase
      ecall_valid = 1'b0;
      tick();
      checkOutput({tag, "_stall_idle"}, cpu_stall, 1'b0);
      checkOutput({tag, "_err_idle"},   err,       1'b0);
      checkOutput({tag, "_we_idle"},    rf_we,     1'b0);
      checkRetained({tag, "_idle"});
   endtask

   // Every register the reset must clear, checked against zero
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_led"},    led_out, 8'h00);
      checkOutput({tag, "_halted"}, halted,  1'b0);
      checkOutput({tag, "_err"},    err,     1'b0);
      checkOutput({tag, "_we"},     rf_we,   1'b0);
      checkRetained(tag);
   endtask

   // Directed scenarios first, then randomized transactions, then the reset,
   // timeout and halt cases that leave the controller in a special state.
   initial begin
      logic [31:0] code;
      int          maxWait;

      mDisp = 32'h0; mDispValid = 1'b0; mWdata = 32'h0; mWaddr = 5'd0;
`ifdef ECALL_TIMEOUT_EN
      maxWait = 3;
`else
      maxWait = 6;
`endif

      #2 reset = 1'b0;
      #1;
      checkResetValues("reset");
      checkOutput("reset_stall", cpu_stall, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      runEcall("read_a5",   32'd5,  32'h0,         32'h0000_00A5, 32'h0, 2, 1'b0);
      runEcall("print_neg", 32'd1,  32'hFFFF_FFFE, 32'h0,         32'h0, 3, 1'b0);
      runEcall("test_3",    32'd11, 32'h0,         32'h0,         32'd3, 0, 1'b0);
      runEcall("bad_7",     32'd7,  32'h0,         32'h0,         32'h0, 0, 1'b0);

      for (int n = 0; n < 16; n++) begin
         case ($urandom_range(0, 3))
            0: code = 32'd1;
            1: code = 32'd5;
            2: code = 32'd11;
            default: begin
               code = $urandom;
               if (serviceKind(code) != 0) code = 32'd7;
            end
         endcase
         runEcall("rand", code, $urandom, $urandom, $urandom,
                  int'($urandom_range(0, maxWait)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a pending read: no write may follow
      applyStimulus(32'd5, 32'h0, 32'h5A5A_5A5A, 32'h0);
      tick();
      confirm_btn = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      mDisp = 32'h0; mDispValid = 1'b0; mWdata = 32'h0; mWaddr = 5'd0;
      checkResetValues("rst_wait");
      ecall_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("rst_wait_no_we", rf_we, 1'b0);
      end
      confirm_btn = 1'b0;
      checkResetValues("rst_wait_after");

`ifdef ECALL_TIMEOUT_EN
      // Read with no button: timeout forces a zero write after 8 cycles
      applyStimulus(32'd5, 32'h0, 32'h1234, 32'h0);
      tick();
      for (int i = 1; i <= 7; i++) begin
         tick();
         checkOutput("to_err_early", err,   1'b0);
         checkOutput("to_we_early",  rf_we, 1'b0);
      end
      tick();
      mWdata = 32'h0;
      mWaddr = 5'd10;
      checkOutput("to_err",   err,      1'b1);
      checkOutput("to_we",    rf_we,    1'b1);
      checkOutput("to_wdata", rf_wdata, 32'h0);
      checkOutput("to_led",   led_out,  8'h00);
      tick();
      checkOutput("to_err_done",   err,       1'b0);
      checkOutput("to_stall_done", cpu_stall, 1'b0);
      ecall_valid = 1'b0;
      tick();
      checkRetained("to_idle");
`endif

      // Exit: absorbing until reset regardless of button and ecall activity
      applyStimulus(32'd10, 32'h0, 32'h0, 32'h0);
      tick();
      checkOutput("halt_halted", halted,    1'b1);
      checkOutput("halt_led",    led_out,   8'h01);
      checkOutput("halt_stall",  cpu_stall, 1'b1);
      for (int i = 0; i < 10; i++) begin
         confirm_btn = 1'($urandom_range(0, 1));
         ecall_valid = 1'($urandom_range(0, 1));
         a7_val      = (i % 2 == 0) ? 32'd1 : 32'd11;
         tick();
         checkOutput("halt_hold_halted", halted,    1'b1);
         checkOutput("halt_hold_led",    led_out,   8'h01);
         checkOutput("halt_hold_stall",  cpu_stall, 1'b1);
         checkOutput("halt_hold_we",     rf_we,     1'b0);
      end
      ecall_valid = 1'b0;
      confirm_btn = 1'b0;
      reset = 1'b0;
      #1;
      checkResetValues("halt_reset");
      checkOutput("halt_reset_stall", cpu_stall, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ecall_controller.md
ECALL_CONTROLLER -- requirements
Module: ecall_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, meaning confirm-wait timeout in clk cycles (used only with ECALL_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ecall_valid  in  1  ecall instruction present in the current cycle; held high by the CPU while stalled.
REQ-005 SHALL have port a7_val  in  32  current a7 (x17) contents, the service code.
REQ-006 SHALL have port a0_val  in  32  current a0 (x10) contents.
REQ-007 SHALL have port io_input  in  32  switch input value.
REQ-008 SHALL have port test_case  in  32  selected test-case number.
REQ-009 SHALL have port confirm_btn  in  1  raw, asynchronous confirm button.
REQ-010 SHALL have port cpu_stall  out  1  freeze PC and writeback.
REQ-011 SHALL have ports rf_we  out  1, rf_waddr  out  5, rf_wdata  out  32, forming the register-file write request; it takes priority over CPU writeback.
REQ-012 SHALL have ports disp_data  out  32, disp_valid  out  1, driving the print latch to the display.
REQ-013 SHALL have ports led_out  out  8 (status LEDs), halted  out  1, err  out  1 (one-cycle error pulse).

Function
REQ-014 States SHALL be IDLE, SHOW, WAIT_IN, WRITE_A0, DONE, HALT.
REQ-015 In IDLE with ecall_valid=1, the block SHALL decode a7_val as follows:
- 1: disp_data<=a0_val, disp_valid<=1, go to SHOW.
- 5: led_out[7]<=1, go to WAIT_IN.
- 10: led_out[0]<=1, go to HALT.
- 11: rf_wdata<=test_case, led_out[1]<=1, go to WRITE_A0.
- Any other value: err=1 for one cycle, stay in IDLE.
REQ-016 cpu_stall SHALL be combinational: 1 when state is SHOW, WAIT_IN, WRITE_A0 or HALT, or when state is IDLE with ecall_valid=1 and a valid code; otherwise 0.
REQ-017 confirm_btn SHALL pass through a 2-flop synchronizer and rising-edge detector; confirm_edge SHALL be a single-cycle pulse.
REQ-018 In SHOW, confirm_edge SHALL cause a transition to DONE; disp_data and disp_valid SHALL keep their values until the next print or reset.
REQ-019 In WAIT_IN, confirm_edge SHALL capture io_input into rf_wdata, clear led_out[7], and cause a transition to WRITE_A0.
REQ-020 In WRITE_A0, the block SHALL drive rf_we=1 and rf_waddr=5'd10 for exactly one cycle, clear led_out[1], and go to DONE.
REQ-021 DONE SHALL last exactly one cycle with cpu_stall=0, ignore ecall_valid, and go to IDLE; this prevents re-triggering the same ecall.
REQ-022 HALT SHALL be absorbing until reset, with halted=1 and cpu_stall=1; ecall_valid and confirm_edge SHALL be ignored.
REQ-023 confirm_edge pulses in IDLE, DONE or HALT SHALL be discarded and not remembered.
REQ-024 Outside WRITE_A0, rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL keep their last values.
REQ-025 Latency from the confirm_btn rising edge to the rf_we pulse SHALL be 4 clk cycles: 2 cycles synchronizer, 1 cycle edge detect, 1 cycle WRITE_A0.

Reset
REQ-026 Assertion of reset (reset=0), in any state, SHALL asynchronously force: state=IDLE; led_out=8'h00; disp_data=0; disp_valid=0; rf_wdata=0; rf_waddr=0; rf_we=0; err=0; halted=0; synchronizer flops=0; timeout counter=0.
REQ-027 A reset asserted mid-WAIT_IN SHALL produce no register-file write.

Configuration
REQ-028 With ECALL_TIMEOUT_EN defined, a counter SHALL run in SHOW and WAIT_IN and clear on every state entry.
- On reaching TIMEOUT_CYCLES-1 in SHOW: err pulses and the state goes to DONE.
- On reaching TIMEOUT_CYCLES-1 in WAIT_IN: err pulses, rf_wdata<=0, led_out[7]<=0, and the state goes to WRITE_A0.
REQ-029 Without ECALL_TIMEOUT_EN, no counter SHALL exist and SHOW and WAIT_IN SHALL wait indefinitely.

Structure
REQ-030 Package ecall_pkg SHALL hold the service-code constants (PRINT_INT=1, READ_INT=5, EXIT=10, READ_TEST=11), the A0_ADDR=5'd10 constant, and the state enum.
REQ-031 The synchronizer and edge detector SHALL be sub-module btn_edge_sync.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- a7=5, ecall_valid held, io_input=32'h0000_00A5, button pressed -> rf_we pulse with addr 10 and data 32'hA5, 4 cycles after the press; then DONE with stall=0 for 1 cycle; then IDLE.
- a7=1, a0=32'hFFFF_FFFE -> disp_data=32'hFFFF_FFFE and disp_valid=1 next cycle; stall held until the button, released one cycle after the edge.
- a7=11, test_case=3 -> rf_we=1, addr 10, data 3 on the 2nd cycle; led_out[1] pulses; stall=1 for 2 cycles.
- a7=10 -> halted=1 and led_out=8'h01 permanently; button and ecall_valid ignored; reset=0 clears both.
- a7=7 -> err pulses for 1 cycle; cpu_stall=0; no rf_we.
- Reset asserted mid-WAIT_IN -> no rf_we, and all outputs at reset values; additionally, with ECALL_TIMEOUT_EN and TIMEOUT_CYCLES=8 in WAIT_IN with no button -> err plus rf_we with data 0 after 8 cycles.
